// File: rtl/mac_result_accumulator.sv
// mac_result_accumulator: sums a programmable-length burst of multiplier
// products into an accumulator, then returns the sum as a low byte
// followed by a high byte on an 8-bit valid/ready output port.
module mac_result_accumulator #(
  parameter int PROD_W = 8,
  parameter int ACC_W  = 12,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  count_in,
  input  logic [PROD_W-1:0] product_in,
  input  logic              prod_valid,
  output logic              prod_ready,
  output logic [7:0]        data_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              overflow
);

  typedef enum logic [1:0] {IDLE, ACCUM, OUT_LO, OUT_HI} state_t;
  typedef logic [ACC_W:0] sum_t;
  typedef logic [15:0]    wide_t;

  localparam logic [CNT_W:0] REM_ONE = {{CNT_W{1'b0}}, 1'b1};
  localparam logic [CNT_W:0] REM_MAX = {1'b1, {CNT_W{1'b0}}};

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W:0]   remaining_q, remaining_d;
  logic             overflow_q, overflow_d;
  logic             prod_ready_q, prod_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;
  logic             busy_q, busy_d;
  logic [7:0]       data_out_q, data_out_d;

  sum_t             sum;
  wide_t            acc_wide_d;
  logic             xfer;

  // Next-state logic: burst setup, accumulation with carry capture, and
  // the two-byte output handshake. Outputs are decoded from the next state
  // so that they come straight out of flops.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    remaining_d = remaining_q;
    overflow_d  = overflow_q;
    sum         = sum_t'(acc_q) + sum_t'(product_in);
    xfer        = (state_q == ACCUM) && prod_valid;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = ACCUM;
          acc_d       = '0;
          overflow_d  = 1'b0;
          remaining_d = (count_in == '0) ? REM_MAX : {1'b0, count_in};
        end
      end
      ACCUM: begin
        if (xfer) begin
          acc_d       = sum[ACC_W-1:0];
          overflow_d  = overflow_q | sum[ACC_W];
          remaining_d = remaining_q - REM_ONE;
          if (remaining_q == REM_ONE) begin
            state_d = OUT_LO;
          end
        end
      end
      OUT_LO: begin
        if (out_ready) begin
          state_d = OUT_HI;
        end
      end
      OUT_HI: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    acc_wide_d   = wide_t'(acc_d);
    prod_ready_d = (state_d == ACCUM);
    out_valid_d  = (state_d == OUT_LO) || (state_d == OUT_HI);
    out_last_d   = (state_d == OUT_HI);
    busy_d       = (state_d != IDLE);
    data_out_d   = 8'h00;
    if (state_d == OUT_LO) begin
      data_out_d = acc_wide_d[7:0];
    end else if (state_d == OUT_HI) begin
      data_out_d = acc_wide_d[15:8];
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      acc_q        <= '0;
      remaining_q  <= '0;
      overflow_q   <= 1'b0;
      prod_ready_q <= 1'b0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      busy_q       <= 1'b0;
      data_out_q   <= 8'h00;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      remaining_q  <= remaining_d;
      overflow_q   <= overflow_d;
      prod_ready_q <= prod_ready_d;
      out_valid_q  <= out_valid_d;
      out_last_q   <= out_last_d;
      busy_q       <= busy_d;
      data_out_q   <= data_out_d;
    end
  end

  assign prod_ready = prod_ready_q;
  assign out_valid  = out_valid_q;
  assign out_last   = out_last_q;
  assign busy       = busy_q;
  assign data_out   = data_out_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_mac_result_accumulator.sv
// Testbench for mac_result_accumulator: a 12-bit and a 9-bit accumulator
// share one stimulus stream; directed vectors plus hand-written sequences
// for backpressure, reset mid-burst and ignored start pulses.
module tb_mac_result_accumulator;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] count_in;
  logic [7:0] product_in;
  logic       prod_valid;
  logic       out_ready;

  logic       prod_ready12, out_valid12, out_last12, busy12, overflow12;
  logic [7:0] data_out12;
  logic       prod_ready9, out_valid9, out_last9, busy9, overflow9;
  logic [7:0] data_out9;

  int checks   = 0;
  int failures = 0;
  int xfer_cnt = 0;

  logic [15:0][7:0] burst_prods;

  typedef struct {
    int               cnt;
    logic [15:0][7:0] prods;
    int               lo12;
    int               hi12;
    int               ovf12;
    int               lo9;
    int               hi9;
    int               ovf9;
  } vec_t;

  vec_t vecs[5];

  mac_result_accumulator #(.PROD_W(8), .ACC_W(12), .CNT_W(4)) dut12 (
    .clk(clk), .rst_n(rst_n), .start(start), .count_in(count_in),
    .product_in(product_in), .prod_valid(prod_valid), .prod_ready(prod_ready12),
    .data_out(data_out12), .out_valid(out_valid12), .out_ready(out_ready),
    .out_last(out_last12), .busy(busy12), .overflow(overflow12)
  );

  mac_result_accumulator #(.PROD_W(8), .ACC_W(9), .CNT_W(4)) dut9 (
    .clk(clk), .rst_n(rst_n), .start(start), .count_in(count_in),
    .product_in(product_in), .prod_valid(prod_valid), .prod_ready(prod_ready9),
    .data_out(data_out9), .out_valid(out_valid9), .out_ready(out_ready),
    .out_last(out_last9), .busy(busy9), .overflow(overflow9)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts accepted product transfers on the 12-bit instance.
  always @(posedge clk) begin
    if (rst_n && prod_valid && prod_ready12) xfer_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  // Runs one burst from IDLE with an always-valid producer and always-ready
  // consumer, returning both instances' bytes and the edge count to IDLE.
  task automatic applyStimulus(input int cnt, output int lo12, output int hi12,
                               output int lastlo, output int lasthi,
                               output int lo9, output int hi9, output int cycles);
    int idx = 0;
    int got = 0;
    int budget = 0;
    int n;
    n = (cnt == 0) ? 16 : cnt;
    lo12 = -1; hi12 = -1; lo9 = -1; hi9 = -1; lastlo = -1; lasthi = -1;
    out_ready = 1'b1;
    start = 1'b1;
    count_in = 4'(cnt);
    tick();
    start = 1'b0;
    cycles = 0;
    while (idx < n && budget < 100) begin
      prod_valid = 1'b1;
      product_in = burst_prods[idx];
      if (prod_ready12) idx++;
      tick();
      cycles++;
      budget++;
    end
    prod_valid = 1'b0;
    while (got < 2 && budget < 100) begin
      if (out_valid12) begin
        if (got == 0) begin
          lo12 = data_out12; lo9 = data_out9; lastlo = out_last12;
        end else begin
          hi12 = data_out12; hi9 = data_out9; lasthi = out_last12;
        end
        got++;
      end
      tick();
      cycles++;
      budget++;
    end
    while (busy12 && budget < 100) begin
      tick();
      cycles++;
      budget++;
    end
    checkOutput("burst_timeout", int'(budget < 100), 1);
  endtask

  initial begin
    int lo12, hi12, lastlo, lasthi, lo9, hi9, cycles, n, base;

    // Directed vectors with hand-computed sums.
    for (int i = 0; i < 5; i++) vecs[i].prods = '0;
    vecs[0].cnt = 3;
    vecs[0].prods[0] = 8'd6; vecs[0].prods[1] = 8'd15; vecs[0].prods[2] = 8'd225;
    vecs[0].lo12 = 'hF6; vecs[0].hi12 = 'h00; vecs[0].ovf12 = 0;
    vecs[0].lo9  = 'hF6; vecs[0].hi9  = 'h00; vecs[0].ovf9  = 0;
    vecs[1].cnt = 0;
    for (int i = 0; i < 16; i++) vecs[1].prods[i] = 8'd225;
    vecs[1].lo12 = 'h10; vecs[1].hi12 = 'h0E; vecs[1].ovf12 = 0;
    vecs[1].lo9  = 'h10; vecs[1].hi9  = 'h00; vecs[1].ovf9  = 1;
    vecs[2].cnt = 1;
    vecs[2].prods[0] = 8'd7;
    vecs[2].lo12 = 'h07; vecs[2].hi12 = 'h00; vecs[2].ovf12 = 0;
    vecs[2].lo9  = 'h07; vecs[2].hi9  = 'h00; vecs[2].ovf9  = 0;
    vecs[3].cnt = 2;
    vecs[3].prods[0] = 8'd255; vecs[3].prods[1] = 8'd255;
    vecs[3].lo12 = 'hFE; vecs[3].hi12 = 'h01; vecs[3].ovf12 = 0;
    vecs[3].lo9  = 'hFE; vecs[3].hi9  = 'h01; vecs[3].ovf9  = 0;
    vecs[4].cnt = 3;
    for (int i = 0; i < 3; i++) vecs[4].prods[i] = 8'd225;
    vecs[4].lo12 = 'hA3; vecs[4].hi12 = 'h02; vecs[4].ovf12 = 0;
    vecs[4].lo9  = 'hA3; vecs[4].hi9  = 'h00; vecs[4].ovf9  = 1;

    rst_n = 1'b0; start = 1'b0; count_in = 4'd0; product_in = 8'd0;
    prod_valid = 1'b0; out_ready = 1'b0;

    // Reset for two cycles, then idle with no start.
    tick(); tick();
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      checkOutput("idle_outputs",
                  int'({prod_ready12, out_valid12, busy12, overflow12, data_out12}), 0);
      tick();
    end

    // Table-driven bursts.
    for (int v = 0; v < 5; v++) begin
      burst_prods = vecs[v].prods;
      n = (vecs[v].cnt == 0) ? 16 : vecs[v].cnt;
      applyStimulus(vecs[v].cnt, lo12, hi12, lastlo, lasthi, lo9, hi9, cycles);
      checkOutput($sformatf("v%0d_lo12", v), lo12, vecs[v].lo12);
      checkOutput($sformatf("v%0d_hi12", v), hi12, vecs[v].hi12);
      checkOutput($sformatf("v%0d_last_lo", v), lastlo, 0);
      checkOutput($sformatf("v%0d_last_hi", v), lasthi, 1);
      checkOutput($sformatf("v%0d_ovf12", v), int'(overflow12), vecs[v].ovf12);
      checkOutput($sformatf("v%0d_lo9", v), lo9, vecs[v].lo9);
      checkOutput($sformatf("v%0d_hi9", v), hi9, vecs[v].hi9);
      checkOutput($sformatf("v%0d_ovf9", v), int'(overflow9), vecs[v].ovf9);
      checkOutput($sformatf("v%0d_cycles", v), cycles, n + 2);
    end

    // Sticky overflow holds through IDLE.
    tick(); tick(); tick();
    checkOutput("ovf9_hold_idle", int'(overflow9), 1);

    // Backpressure and producer bubbles.
    out_ready = 1'b0;
    base = xfer_cnt;
    start = 1'b1; count_in = 4'd2;
    tick();
    start = 1'b0;
    checkOutput("bp_ovf9_cleared", int'(overflow9), 0);
    checkOutput("bp_first_ready", int'(prod_ready12), 1);
    prod_valid = 1'b1; product_in = 8'd4; tick();
    prod_valid = 1'b0; product_in = 8'd77; tick();
    tick();
    prod_valid = 1'b1; product_in = 8'd8; tick();
    product_in = 8'd99;
    for (int c = 0; c < 3; c++) begin
      checkOutput("bp_lo_valid", int'(out_valid12), 1);
      checkOutput("bp_lo_data", int'(data_out12), 'h0C);
      checkOutput("bp_lo_last", int'(out_last12), 0);
      checkOutput("bp_lo_noready", int'(prod_ready12), 0);
      tick();
    end
    checkOutput("bp_lo_data_final", int'(data_out12), 'h0C);
    out_ready = 1'b1; tick();
    out_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      checkOutput("bp_hi_valid", int'(out_valid12), 1);
      checkOutput("bp_hi_data", int'(data_out12), 'h00);
      checkOutput("bp_hi_last", int'(out_last12), 1);
      tick();
    end
    out_ready = 1'b1; tick();
    prod_valid = 1'b0; out_ready = 1'b0;
    checkOutput("bp_idle", int'(busy12), 0);
    checkOutput("bp_xfers", xfer_cnt - base, 2);

    // Reset in the middle of a burst discards it.
    start = 1'b1; count_in = 4'd4; tick();
    start = 1'b0;
    prod_valid = 1'b1; product_in = 8'd50; tick();
    product_in = 8'd60; tick();
    rst_n = 1'b0; tick();
    rst_n = 1'b1; prod_valid = 1'b0; out_ready = 1'b1;
    checkOutput("rst_busy", int'(busy12), 0);
    checkOutput("rst_ready", int'(prod_ready12), 0);
    checkOutput("rst_valid", int'(out_valid12), 0);
    checkOutput("rst_data", int'(data_out12), 0);
    for (int c = 0; c < 3; c++) begin
      tick();
      checkOutput("rst_no_output", int'(out_valid12), 0);
    end
    burst_prods = '0;
    burst_prods[0] = 8'd7;
    applyStimulus(1, lo12, hi12, lastlo, lasthi, lo9, hi9, cycles);
    checkOutput("rst_after_lo", lo12, 'h07);
    checkOutput("rst_after_hi", hi12, 'h00);

    // Start ignored in ACCUM and on the OUT_HI handshake edge.
    out_ready = 1'b0;
    start = 1'b1; count_in = 4'd2; tick();
    start = 1'b0;
    prod_valid = 1'b1; product_in = 8'd10;
    start = 1'b1; count_in = 4'd5; tick();
    start = 1'b0; product_in = 8'd20; tick();
    prod_valid = 1'b0;
    checkOutput("ign_lo_valid", int'(out_valid12), 1);
    checkOutput("ign_lo_data", int'(data_out12), 'h1E);
    out_ready = 1'b1; tick();
    checkOutput("ign_hi_last", int'(out_last12), 1);
    start = 1'b1; count_in = 4'd1; tick();
    start = 1'b0; out_ready = 1'b0;
    checkOutput("ign_idle_busy", int'(busy12), 0);
    checkOutput("ign_idle_ready", int'(prod_ready12), 0);
    tick();
    checkOutput("ign_still_idle", int'(busy12), 0);
    burst_prods = '0;
    burst_prods[0] = 8'd3;
    applyStimulus(1, lo12, hi12, lastlo, lasthi, lo9, hi9, cycles);
    checkOutput("ign_next_lo", lo12, 'h03);
    checkOutput("ign_next_hi", hi12, 'h00);
    checkOutput("ign_next_cycles", cycles, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
